// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
// The optional subtract feature is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width: clog2 of WIDTH, never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_bit.sv
// serial_adder_bit: one-bit full adder plus the running carry flop.
// The carry can be loaded (start of operation) or cleared by reset.
module serial_adder_bit (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_val,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic co,
    output logic carry
);

    // Combinational full adder on the current operand bits and stored carry
    always_comb begin
        s  = a ^ b ^ carry;
        co = (a & b) | (carry & (a ^ b));
    end

    // Carry flop: reset wins, then load, then advance with the carry-out
    always_ff @(posedge clk) begin
        if (rst)
            carry <= 1'b0;
        else if (load)
            carry <= load_val;
        else if (en)
            carry <= co;
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first.
// Operands are captured in IDLE, WIDTH edges of RUN produce the result,
// and DONE holds it until the consumer takes it.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b when sub=1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t state, next_state;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic running;
    logic last;
    logic sub_op;
    logic [WIDTH-1:0] b_load;
    logic carry_load;
    logic bit_s;
    logic bit_co;
    logic carry_q;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert B on load and force the carry in
    always_comb begin
        b_load     = sub_op ? ~b : b;
        carry_load = sub_op ? 1'b1 : cin;
    end

    // Handshake and sequencing qualifiers
    always_comb begin
        accept   = in_valid && (state == ST_IDLE);
        running  = (state == ST_RUN);
        last     = running && (cnt == LAST);
        res_next = {bit_s, res_sr[WIDTH-1:1]};
    end

    serial_adder_bit u_bit (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (carry_load),
        .en       (running),
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .s        (bit_s),
        .co       (bit_co),
        .carry    (carry_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid)  next_state = ST_RUN;
            ST_RUN:  if (last)      next_state = ST_DONE;
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default:                next_state = ST_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE, valid only in DONE
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand/result shift registers and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b_load;
            res_sr <= '0;
            cnt    <= '0;
        end else if (running) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            cnt    <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Result registers: updated only on the final RUN edge, else held
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last) begin
            sum  <= res_next;
            cout <= bit_co;
        end
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands a, b, cin presented.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  registered final carry.

Function
REQ-013 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch a, b and cin into the operand shift registers and carry flop, clear the bit counter, go to RUN.
REQ-015 in_valid while not in IDLE is ignored, and operands are not sampled.
REQ-016 RUN: each edge adds bit 0 of the A and B shift registers plus the carry flop; the sum bit shifts into the MSB of the result shift register; A and B shift right by 1; the carry flop takes the carry-out; the counter increments.
REQ-017 On the RUN edge where counter==WIDTH-1, copy the result shift register (including that edge's bit) to sum and the carry-out to cout, then go to DONE.
REQ-018 Latency: out_valid rises exactly WIDTH edges after the accepting edge.
REQ-019 DONE: out_valid=1, in_ready=0; sum and cout are held stable.
REQ-020 DONE with out_ready=1: go to IDLE; out_valid=0 on the next cycle.
REQ-021 DONE with out_ready=0: stay in DONE indefinitely with outputs unchanged.
REQ-022 sum and cout change only on entry to DONE or on rst; they hold their previous values through IDLE and RUN.
REQ-023 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
REQ-024 Throughput: at most one operation per WIDTH+2 cycles; no accept is possible in the same cycle as a DONE->IDLE transition.

Reset
REQ-025 rst=1 at any edge, including mid-RUN or in DONE, forces IDLE, counter=0, all shift registers 0, carry flop 0, sum=0, cout=0, out_valid=0.
REQ-026 in_ready=1 on the first cycle after reset deasserts.
REQ-027 An aborted operation produces no result.

Configuration
REQ-028 Macro SERIAL_ADDER_SUB_EN defined: adds port sub (input, 1, sampled with the operands).
REQ-029 With sub=1: B is latched inverted, the carry flop loads 1 and cin is ignored; result is a - b, and cout=1 means no borrow.
REQ-030 With sub=0: behaviour is identical to the macro-undefined build.
REQ-031 Macro undefined: no sub port; addition only.

Structure
REQ-032 Package serial_adder_pkg: state enum type, default WIDTH constant, and counter-width function (clog2 of WIDTH).
REQ-033 One sub-module, serial_adder_bit: 1-bit sum/carry logic plus the carry flop, with synchronous load and clear.

Verification (WIDTH=8)
REQ-034 a=0x0F, b=0x01, cin=0 -> after 8 edges out_valid=1, sum=0x10, cout=0.
REQ-035 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-036 Backpressure: result 0x10; hold out_ready=0 for 5 cycles and pulse in_valid with a=0x22 during DONE -> sum stays 0x10, in_ready=0, new operands ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-RUN: assert rst after 3 RUN edges -> next cycle out_valid=0, sum=0, in_ready=1; then 0x03+0x04 -> sum=0x07 after 8 edges.
REQ-038 Back-to-back: two operations with out_ready tied 1 -> second accept no earlier than 10 cycles after the first; both results correct.
REQ-039 SERIAL_ADDER_SUB_EN build: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
